// File: rtl/round_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : round_controller_pkg
//  Purpose  : State encodings, arrow codes and LFSR helpers shared by the
//             rhythm-game round controller and its arrow generator.
//  Revision : 1.0  initial release
// ============================================================================
package round_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SHOW  = 2'd1;
    localparam state_t c_ST_JUDGE = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

    localparam logic [2:0] c_ARROW_NONE  = 3'd0;
    localparam logic [2:0] c_ARROW_UP    = 3'd1;
    localparam logic [2:0] c_ARROW_DOWN  = 3'd2;
    localparam logic [2:0] c_ARROW_LEFT  = 3'd3;
    localparam logic [2:0] c_ARROW_RIGHT = 3'd4;

    // Feedback taps q7, q5, q4, q3
    localparam logic [7:0] c_LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_advance(input logic [7:0] value);
        return {value[6:0], ^(value & c_LFSR_TAPS)};
    endfunction

    // Two low LFSR bits select UP..RIGHT
    function automatic logic [2:0] arrow_from_bits(input logic [1:0] low_bits);
        return {1'b0, low_bits} + c_ARROW_UP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_controller_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : arrow_lfsr
//  Purpose  : 8-bit Fibonacci LFSR producing the pseudo-random arrow stream.
//  Revision : 1.0  initial release
// ============================================================================
module arrow_lfsr
    import round_controller_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] value
);

    logic [7:0] r_value_q;
    logic [7:0] w_value_d;

    always_comb begin
        w_value_d = r_value_q;
        if (load) begin
            w_value_d = SEED;
        end else if (step) begin
            w_value_d = lfsr_advance(r_value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_q <= SEED;
        end else begin
            r_value_q <= w_value_d;
        end
    end

    assign value = r_value_q;

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : round_controller
//  Purpose  : Sequences arrow windows for a rhythm game, judges each window
//             against the comparator hit flag and keeps score/combo/misses.
//  Revision : 1.0  initial release
// ============================================================================
module round_controller
    import round_controller_pkg::*;
#(
    parameter int         WINDOW_TICKS = 8,
    parameter int         STEPS        = 32,
    parameter int         MAX_MISSES   = 3,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic       hit,
    output logic [2:0] target,
    output logic       window_end,
    output logic [7:0] score,
    output logic [5:0] combo,
    output logic [2:0] misses,
    output logic       playing,
    output logic       game_over
);

    localparam int         c_TICK_W     = (WINDOW_TICKS > 2) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(WINDOW_TICKS - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [7:0] c_STEP_LAST  = 8'(STEPS - 1);
    localparam logic [2:0] c_MISS_LIMIT = 3'(MAX_MISSES);
    localparam logic [7:0] c_SCORE_MAX  = 8'hFF;
    localparam logic [5:0] c_COMBO_MAX  = 6'h3F;

    state_t              r_state_q,      w_state_d;
    logic [c_TICK_W-1:0] r_tick_cnt_q,   w_tick_cnt_d;
    logic [7:0]          r_step_q,       w_step_d;
    logic [7:0]          r_score_q,      w_score_d;
    logic [5:0]          r_combo_q,      w_combo_d;
    logic [2:0]          r_misses_q,     w_misses_d;
    logic [2:0]          r_target_q,     w_target_d;
    logic                r_window_end_q, w_window_end_d;
    logic                r_playing_q,    w_playing_d;
    logic                r_game_over_q,  w_game_over_d;

    logic       w_idle_like;
    logic       w_begin_song;
    logic       w_window_close;
    logic       w_song_over;
    logic       w_lfsr_step;
    logic [2:0] w_miss_inc;
    logic [7:0] w_lfsr_value;
    logic [7:0] w_arrow_src;

    assign w_idle_like    = (r_state_q == c_ST_IDLE) || (r_state_q == c_ST_DONE);
    assign w_begin_song   = w_idle_like && start;
    assign w_window_close = (r_state_q == c_ST_SHOW) && tick && (r_tick_cnt_q == c_TICK_LAST);
    assign w_miss_inc     = r_misses_q + 3'd1;
    assign w_song_over    = (!hit && (w_miss_inc == c_MISS_LIMIT)) || (r_step_q == c_STEP_LAST);
    assign w_lfsr_step    = (r_state_q == c_ST_JUDGE) && !w_song_over;

    arrow_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_begin_song),
        .step  (w_lfsr_step),
        .value (w_lfsr_value)
    );

    // State and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= c_ST_IDLE;
            r_tick_cnt_q   <= '0;
            r_step_q       <= '0;
            r_score_q      <= '0;
            r_combo_q      <= '0;
            r_misses_q     <= '0;
            r_target_q     <= c_ARROW_NONE;
            r_window_end_q <= 1'b0;
            r_playing_q    <= 1'b0;
            r_game_over_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_tick_cnt_q   <= w_tick_cnt_d;
            r_step_q       <= w_step_d;
            r_score_q      <= w_score_d;
            r_combo_q      <= w_combo_d;
            r_misses_q     <= w_misses_d;
            r_target_q     <= w_target_d;
            r_window_end_q <= w_window_end_d;
            r_playing_q    <= w_playing_d;
            r_game_over_q  <= w_game_over_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE,
            c_ST_DONE:  if (start) w_state_d = c_ST_SHOW;
            c_ST_SHOW:  if (w_window_close) w_state_d = c_ST_JUDGE;
            c_ST_JUDGE: w_state_d = w_song_over ? c_ST_DONE : c_ST_SHOW;
            default:    w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_tick_cnt_d = r_tick_cnt_q;
        w_step_d     = r_step_q;
        w_score_d    = r_score_q;
        w_combo_d    = r_combo_q;
        w_misses_d   = r_misses_q;
        case (r_state_q)
            c_ST_IDLE,
            c_ST_DONE: begin
                if (start) begin
                    w_tick_cnt_d = '0;
                    w_step_d     = '0;
                    w_score_d    = '0;
                    w_combo_d    = '0;
                    w_misses_d   = '0;
                end
            end
            c_ST_SHOW: begin
                if (tick) begin
                    w_tick_cnt_d = w_window_close ? '0 : (r_tick_cnt_q + c_TICK_ONE);
                end
            end
            c_ST_JUDGE: begin
                if (hit) begin
                    w_score_d = (r_score_q == c_SCORE_MAX) ? r_score_q : (r_score_q + 8'd1);
                    w_combo_d = (r_combo_q == c_COMBO_MAX) ? r_combo_q : (r_combo_q + 6'd1);
                end else begin
                    w_misses_d = w_miss_inc;
                    w_combo_d  = '0;
                end
                if (!w_song_over) begin
                    w_step_d = r_step_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs follow the next state so they line up with the registered state
    always_comb begin
        w_arrow_src = w_lfsr_value;
        if (w_begin_song) begin
            w_arrow_src = SEED;
        end else if (w_lfsr_step) begin
            w_arrow_src = lfsr_advance(w_lfsr_value);
        end

        w_target_d     = c_ARROW_NONE;
        w_window_end_d = 1'b0;
        w_playing_d    = 1'b0;
        w_game_over_d  = 1'b0;
        case (w_state_d)
            c_ST_SHOW: begin
                w_playing_d = 1'b1;
                w_target_d  = arrow_from_bits(w_arrow_src[1:0]);
            end
            c_ST_JUDGE: begin
                w_playing_d    = 1'b1;
                w_window_end_d = 1'b1;
                w_target_d     = arrow_from_bits(w_arrow_src[1:0]);
            end
            c_ST_DONE: w_game_over_d = 1'b1;
            default: ;
        endcase
    end

    assign target     = r_target_q;
    assign window_end = r_window_end_q;
    assign score      = r_score_q;
    assign combo      = r_combo_q;
    assign misses     = r_misses_q;
    assign playing    = r_playing_q;
    assign game_over  = r_game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_controller
//  Purpose  : Randomised and directed checks of round_controller against a
//             song-level reference model (two instances: 2 and 7 miss limits).
//  Revision : 1.0  initial release
// ============================================================================
module tb_round_controller;

    localparam int         c_W     = 4;
    localparam int         c_STEPS = 4;
    localparam logic [7:0] c_SEED  = 8'hA5;

    localparam int c_PH_IDLE  = 0;
    localparam int c_PH_SHOW  = 1;
    localparam int c_PH_JUDGE = 2;
    localparam int c_PH_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, tick, hit;

    logic [2:0] target_a, target_b, misses_a, misses_b;
    logic       wend_a, wend_b, playing_a, playing_b, over_a, over_b;
    logic [7:0] score_a, score_b;
    logic [5:0] combo_a, combo_b;

    round_controller #(
        .WINDOW_TICKS (c_W), .STEPS (c_STEPS), .MAX_MISSES (2), .SEED (c_SEED)
    ) u_dut_a (
        .clk (clk), .rst (rst), .start (start), .tick (tick), .hit (hit),
        .target (target_a), .window_end (wend_a), .score (score_a), .combo (combo_a),
        .misses (misses_a), .playing (playing_a), .game_over (over_a)
    );

    round_controller #(
        .WINDOW_TICKS (c_W), .STEPS (c_STEPS), .MAX_MISSES (7), .SEED (c_SEED)
    ) u_dut_b (
        .clk (clk), .rst (rst), .start (start), .tick (tick), .hit (hit),
        .target (target_b), .window_end (wend_b), .score (score_b), .combo (combo_b),
        .misses (misses_b), .playing (playing_b), .game_over (over_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state, index 0 -> dut_a, 1 -> dut_b
    int m_phase [2];
    int m_ticks [2];
    int m_step  [2];
    int m_lfsr  [2];
    int m_score [2];
    int m_combo [2];
    int m_miss  [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int miss_limit(input int m);
        return (m == 0) ? 2 : 7;
    endfunction

    function automatic int next_lfsr(input int l);
        int nb;
        nb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 8'hFF) | nb;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_phase[m] = c_PH_IDLE;
            m_ticks[m] = 0; m_step[m] = 0; m_lfsr[m] = c_SEED;
            m_score[m] = 0; m_combo[m] = 0; m_miss[m] = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic t, input logic h);
        if (r) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            case (m_phase[m])
                c_PH_IDLE, c_PH_DONE: begin
                    if (s) begin
                        m_phase[m] = c_PH_SHOW;
                        m_ticks[m] = 0; m_step[m] = 0; m_lfsr[m] = c_SEED;
                        m_score[m] = 0; m_combo[m] = 0; m_miss[m] = 0;
                    end
                end
                c_PH_SHOW: begin
                    if (t) begin
                        m_ticks[m]++;
                        if (m_ticks[m] == c_W) begin
                            m_ticks[m] = 0;
                            m_phase[m] = c_PH_JUDGE;
                        end
                    end
                end
                default: begin
                    if (h) begin
                        if (m_score[m] < 255) m_score[m]++;
                        if (m_combo[m] < 63)  m_combo[m]++;
                    end else begin
                        m_miss[m]++;
                        m_combo[m] = 0;
                    end
                    if (m_miss[m] == miss_limit(m) || m_step[m] == c_STEPS - 1) begin
                        m_phase[m] = c_PH_DONE;
                    end else begin
                        m_step[m]++;
                        m_lfsr[m]  = next_lfsr(m_lfsr[m]);
                        m_phase[m] = c_PH_SHOW;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_dut(input int m, input logic [2:0] tgt, input logic we,
                               input logic [7:0] sc, input logic [5:0] cb,
                               input logic [2:0] ms, input logic pl, input logic go);
        string p;
        bit    active;
        p      = (m == 0) ? "a" : "b";
        active = (m_phase[m] == c_PH_SHOW) || (m_phase[m] == c_PH_JUDGE);
        check_val({p, ".target"},     tgt, active ? (m_lfsr[m] % 4) + 1 : 0);
        check_val({p, ".window_end"}, we,  m_phase[m] == c_PH_JUDGE);
        check_val({p, ".score"},      sc,  m_score[m]);
        check_val({p, ".combo"},      cb,  m_combo[m]);
        check_val({p, ".misses"},     ms,  m_miss[m]);
        check_val({p, ".playing"},    pl,  active);
        check_val({p, ".game_over"},  go,  m_phase[m] == c_PH_DONE);
    endtask

    task automatic drive(input logic r, input logic s, input logic t, input logic h);
        rst = r; start = s; tick = t; hit = h;
        @(posedge clk);
        model_step(r, s, t, h);
        cyc++;
        #1;
        compare_dut(0, target_a, wend_a, score_a, combo_a, misses_a, playing_a, over_a);
        compare_dut(1, target_b, wend_b, score_b, combo_b, misses_b, playing_b, over_b);
    endtask

    // mode 0: hit held high, 1: hit held low, 2: hit on even steps only
    task automatic play_song(input int mode, input int n);
        logic h;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       h = 1'b1;
                1:       h = 1'b0;
                default: h = (m_step[1] % 2 == 0);
            endcase
            drive(1'b0, 1'b0, (cyc % 3 == 2), h);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tick = 1'b0; hit = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("reset.target", target_a, 0);
        check_val("reset.playing", playing_a, 0);

        // First song: start gives arrow 2 from seed A5
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("start.playing", playing_a, 1);
        check_val("start.target", target_a, 2);
        for (int i = 0; i < 80; i++) drive(1'b0, 1'b0, (cyc % 3 == 2), 1'b1);
        check_val("allhit.score", score_a, 4);
        check_val("allhit.combo", combo_a, 4);
        check_val("allhit.misses", misses_a, 0);
        check_val("allhit.game_over", over_a, 1);
        check_val("allhit.target", target_a, 0);

        play_song(1, 80);
        check_val("allmiss.misses", misses_a, 2);
        check_val("allmiss.combo", combo_a, 0);
        check_val("allmiss.game_over", over_a, 1);
        check_val("allmiss.b_misses", misses_b, 4);

        play_song(2, 80);
        check_val("alt.score", score_b, 2);
        check_val("alt.misses", misses_b, 2);
        check_val("alt.combo", combo_b, 0);
        check_val("alt.game_over", over_b, 1);

        // Reset wins over start and tick mid-window
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, (cyc % 3 == 2), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("rstpri.playing", playing_a, 0);
        check_val("rstpri.target", target_a, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("restart.target", target_a, 2);

        // Start and hit mid-window are ignored; the window is judged a miss
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, (i == 3), (cyc % 3 == 2), (i == 5));
        end
        check_val("ignore.misses", misses_a, 1);
        check_val("ignore.score", score_a, 0);
        check_val("ignore.playing", playing_a, 1);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter WINDOW_TICKS, default 8, tick strobes per step window (>=2).
REQ-002 Parameter STEPS, default 32, steps per song (1..255).
REQ-003 Parameter MAX_MISSES, default 3, misses that end the game (1..7).
REQ-004 Parameter SEED, default 8'hA5, LFSR start value (nonzero).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level, sampled each cycle; begins a song from IDLE or DONE.
REQ-008 tick  in  1  one-cycle timebase strobe (e.g. 1 kHz enable).
REQ-009 hit  in  1  sticky match flag from the downstream comparator.
REQ-010 target  out  3  arrow the player must press; 3'd0 = no arrow.
REQ-011 window_end  out  1  one-cycle pulse closing a window; drives comparator clear.
REQ-012 score  out  8  hits this song, saturating.
REQ-013 combo  out  6  consecutive hits, saturating.
REQ-014 misses  out  3  misses this song.
REQ-015 playing  out  1  high in SHOW or JUDGE.
REQ-016 game_over  out  1  high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, SHOW, JUDGE, DONE.
REQ-018 IDLE: target=0; start=1 -> SHOW next cycle, clearing score, combo, misses, step count, tick count, loading LFSR=SEED.
REQ-019 SHOW: target = {1'b0, lfsr[1:0]} + 1 (range 1..4), held stable for the whole window.
REQ-020 SHOW: tick count increments only on tick=1; on tick=1 with count==WINDOW_TICKS-1 -> JUDGE, count cleared.
REQ-021 JUDGE lasts exactly one cycle; window_end=1 in that cycle only; target still valid.
REQ-022 JUDGE samples hit in that same cycle: hit=1 -> score+1 (hold at 255), combo+1 (hold at 63); hit=0 -> misses+1, combo=0.
REQ-023 JUDGE exit: if updated misses==MAX_MISSES or step count==STEPS-1 -> DONE; else step count+1, LFSR advances one step, -> SHOW.
REQ-024 LFSR: 8-bit, shift left, new bit0 = q7^q5^q4^q3; advances only on JUDGE->SHOW.
REQ-025 DONE: target=0, score/combo/misses frozen; start=1 -> behaves as REQ-018.
REQ-026 start in SHOW or JUDGE SHALL be ignored.
REQ-027 tick in JUDGE, IDLE or DONE SHALL be ignored (no count change).
REQ-028 hit outside JUDGE SHALL have no effect.
REQ-029 Latency: first window_end occurs on the cycle after the WINDOW_TICKS-th tick seen in SHOW.

Reset
REQ-030 rst=1 at any clock edge, including mid-window or in JUDGE, SHALL force IDLE next cycle.
REQ-031 Reset values: target=0, window_end=0, score=0, combo=0, misses=0, playing=0, game_over=0, LFSR=SEED, counters=0.
REQ-032 rst SHALL take priority over start and tick in the same cycle.

Structure
REQ-033 Shared package SHALL hold state encodings, arrow codes (NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4) and LFSR tap constants.
REQ-034 The LFSR SHALL be a sub-module named arrow_lfsr (inputs clk, rst, load, step; output 8-bit value).
REQ-035 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (WINDOW_TICKS=4, STEPS=4, MAX_MISSES=2, tick every 3rd cycle)
REQ-036 Reset then start pulse -> playing=1, target=2 (SEED A5), window_end after 4th tick, one cycle wide.
REQ-037 hit=1 held across JUDGE for all 4 steps -> score=4, combo=4, misses=0, game_over=1, target=0.
REQ-038 hit=0 two windows -> misses=2, combo=0, DONE after 2nd JUDGE; further ticks change nothing.
REQ-039 Alternate hit/miss with MAX_MISSES=7 -> final score=2, misses=2, combo reset on each miss; target sequence matches LFSR model.
REQ-040 rst asserted during SHOW with start=1 same cycle -> IDLE, all outputs at reset values; later start restarts with target=2.
REQ-041 start pulsed during SHOW and hit pulsed mid-window only -> no restart; hit ignored outside JUDGE, step counted as miss.
